bcd_updown_counter_n: RTL and testbench

Parametrised multi-digit BCD up/down counter. It is the successor to the team's single-digit 0–9 up/down counter. It adds N-digit cascaded counting, count enable, synchronous parallel load with digit validation, and a terminal-count output for chaining several instances. It sits under display and timekeeping logic wherever a decimal count of more than one digit is needed.

---
 rtl/bcd_updown_counter_n.sv | 94 +++++++++
 tb/tb_bcd_updown_counter_n.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter_n.sv
// Multi-digit cascaded BCD up/down counter with validated parallel load and terminal count.
// Optional define BCD_SATURATE_EN: hold at all-9s / all-0s instead of wrapping.
module bcd_updown_counter_n #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err
);

  logic [4*DIGITS-1:0] cnt_q, cnt_d;
  logic                wrap_q, wrap_d;
  logic                load_err_q, load_err_d;

  logic [DIGITS-1:0]   dig_bnd;
  logic [DIGITS-1:0]   low_bnd;
  logic                all_bnd;
  logic                bnd_acc;

  // A digit may only step when every digit below it sits at the direction's boundary.
  always_comb begin
    dig_bnd = '0;
    low_bnd = '0;
    bnd_acc = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (up_down) begin
        dig_bnd[k] = (cnt_q[4*k +: 4] == 4'd9);
      end else begin
        dig_bnd[k] = (cnt_q[4*k +: 4] == 4'd0);
      end
      low_bnd[k] = bnd_acc;
      bnd_acc    = bnd_acc & dig_bnd[k];
    end
    all_bnd = bnd_acc;
  end

  always_comb begin
    cnt_d      = cnt_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (load_val[4*k +: 4] > 4'd9) begin
          cnt_d[4*k +: 4] = 4'd0;
          load_err_d      = 1'b1;
        end else begin
          cnt_d[4*k +: 4] = load_val[4*k +: 4];
        end
      end
    end else if (en) begin
`ifdef BCD_SATURATE_EN
      if (!all_bnd) begin
`else
      wrap_d = all_bnd;
      begin
`endif
        for (int k = 0; k < DIGITS; k++) begin
          if (low_bnd[k]) begin
            if (up_down) begin
              cnt_d[4*k +: 4] = (cnt_q[4*k +: 4] == 4'd9) ? 4'd0 : cnt_q[4*k +: 4] + 4'd1;
            end else begin
              cnt_d[4*k +: 4] = (cnt_q[4*k +: 4] == 4'd0) ? 4'd9 : cnt_q[4*k +: 4] - 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign bcd_out  = cnt_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;
  assign tc       = en & all_bnd;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Directed bench for bcd_updown_counter_n (DIGITS = 2); expectations derived from decimal arithmetic.
// Build with BCD_SATURATE_EN defined to exercise the saturating variant.
module tb_bcd_updown_counter_n;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up_down;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] bcd_out;
  logic       tc;
  logic       wrap;
  logic       load_err;

  int check_count = 0;
  int pass_count  = 0;

  bcd_updown_counter_n #(.DIGITS(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up_down  (up_down),
    .load     (load),
    .load_val (load_val),
    .bcd_out  (bcd_out),
    .tc       (tc),
    .wrap     (wrap),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] toBcd(input int v);
    int m;
    m = ((v % 100) + 100) % 100;
    return 8'((m / 10) * 16 + (m % 10));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drive one set of inputs, let one rising edge pass, and return 1 time unit after it.
  task automatic applyStimulus(input logic en_i, input logic up_i, input logic load_i, input logic [7:0] val_i);
    en       = en_i;
    up_down  = up_i;
    load     = load_i;
    load_val = val_i;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int v;
    rst_n    = 1'b0;
    en       = 1'b0;
    up_down  = 1'b1;
    load     = 1'b0;
    load_val = 8'h00;
    #2;
    checkOutput("reset_bcd", 32'(bcd_out), 32'h00);
    checkOutput("reset_wrap", 32'(wrap), 32'h0);
    checkOutput("reset_load_err", 32'(load_err), 32'h0);
    checkOutput("reset_tc_en0", 32'(tc), 32'h0);
    #10;
    rst_n = 1'b1;

    // Full up sweep through wrap
    for (int i = 1; i <= 100; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      checkOutput("up_bcd", 32'(bcd_out), 32'(toBcd(i)));
      checkOutput("up_wrap", 32'(wrap), 32'(i == 100));
      checkOutput("up_tc", 32'(tc), 32'((i % 100) == 99));
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("up_after_wrap_bcd", 32'(bcd_out), 32'h01);
    checkOutput("up_after_wrap_wrap", 32'(wrap), 32'h0);

    // Load 0x10 then count down through 0x00 -> 0x99
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h10);
    checkOutput("load10_bcd", 32'(bcd_out), 32'h10);
    checkOutput("load10_err", 32'(load_err), 32'h0);
    for (int j = 1; j <= 11; j++) begin
      v = 10 - j;
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      checkOutput("down_bcd", 32'(bcd_out), 32'(toBcd(v)));
      checkOutput("down_wrap", 32'(wrap), 32'(j == 11));
      checkOutput("down_tc", 32'(tc), 32'(v == 0));
    end

    // Load validation, en ignored during load
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h5C);
    checkOutput("load5c_bcd", 32'(bcd_out), 32'h50);
    checkOutput("load5c_err", 32'(load_err), 32'h1);
    checkOutput("load5c_wrap", 32'(wrap), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h37);
    checkOutput("load37_bcd", 32'(bcd_out), 32'h37);
    checkOutput("load37_err", 32'(load_err), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hA3);
    checkOutput("loada3_bcd", 32'(bcd_out), 32'h03);
    checkOutput("loada3_err", 32'(load_err), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF);
    checkOutput("loadff_bcd", 32'(bcd_out), 32'h00);
    checkOutput("loadff_err", 32'(load_err), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("load_err_pulse_end", 32'(load_err), 32'h0);

    // Load at all-9s with en=1 must not wrap
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h99);
    checkOutput("tc_en0_at99", 32'(tc), 32'h0);
    en = 1'b1;
    #1;
    checkOutput("tc_en1_up_at99", 32'(tc), 32'h1);
    up_down = 1'b0;
    #1;
    checkOutput("tc_en1_down_at99", 32'(tc), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h12);
    checkOutput("load_over_wrap_bcd", 32'(bcd_out), 32'h12);
    checkOutput("load_over_wrap_wrap", 32'(wrap), 32'h0);

    // Hold and direction switch
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h42);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkOutput("hold_bcd", 32'(bcd_out), 32'h42);
      checkOutput("hold_wrap", 32'(wrap), 32'h0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("toggle1_bcd", 32'(bcd_out), 32'h43);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("toggle2_bcd", 32'(bcd_out), 32'h42);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("toggle3_bcd", 32'(bcd_out), 32'h43);

    // Asynchronous reset between edges
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h57);
    checkOutput("preload57_bcd", 32'(bcd_out), 32'h57);
    load = 1'b0;
    #3;
    rst_n   = 1'b0;
    up_down = 1'b0;
    #1;
    checkOutput("async_rst_bcd", 32'(bcd_out), 32'h00);
    checkOutput("async_rst_wrap", 32'(wrap), 32'h0);
    checkOutput("async_rst_tc_down", 32'(tc), 32'h1);
    up_down = 1'b1;
    #1;
    checkOutput("async_rst_tc_up", 32'(tc), 32'h0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("post_rst_bcd", 32'(bcd_out), 32'h01);
    checkOutput("post_rst_wrap", 32'(wrap), 32'h0);

    // Boundary behaviour: saturate or wrap
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h98);
`ifdef BCD_SATURATE_EN
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      checkOutput("sat_up_bcd", 32'(bcd_out), 32'h99);
      checkOutput("sat_up_wrap", 32'(wrap), 32'h0);
      checkOutput("sat_up_tc", 32'(tc), 32'h1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h01);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      checkOutput("sat_down_bcd", 32'(bcd_out), 32'h00);
      checkOutput("sat_down_wrap", 32'(wrap), 32'h0);
      checkOutput("sat_down_tc", 32'(tc), 32'h1);
    end
`else
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("wrap_up_bcd_99", 32'(bcd_out), 32'h99);
    checkOutput("wrap_up_tc", 32'(tc), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("wrap_up_bcd_00", 32'(bcd_out), 32'h00);
    checkOutput("wrap_up_wrap", 32'(wrap), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h01);
    checkOutput("wrap_down_pulse_end", 32'(wrap), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("wrap_down_bcd_00", 32'(bcd_out), 32'h00);
    checkOutput("wrap_down_wrap0", 32'(wrap), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("wrap_down_bcd_99", 32'(bcd_out), 32'h99);
    checkOutput("wrap_down_wrap1", 32'(wrap), 32'h1);
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
